// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (LSB first) feeding a small first-word-fall-through byte FIFO.
// Bit period is latched from i_Clk_per_bit at each start edge; error flags are sticky.
module uart_rx_fifo #(
  parameter int CPB_W       = 12,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_Clock,
  input  logic             i_Rst_L,
  input  logic             i_RX_Serial,
  input  logic [CPB_W-1:0] i_Clk_per_bit,
  input  logic             i_RD,
  input  logic             i_Clr_Err,
  output logic [7:0]       o_RX_Byte,
  output logic             o_RX_DV,
  output logic             o_Full,
  output logic             o_Frame_Err,
  output logic             o_Overrun,
  output logic             o_RX_Active
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [CPB_W-1:0] CNT_ONE = CPB_W'(1);
  localparam logic [PW-1:0]    PTR_ONE = PW'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

  state_t           state;
  logic [CPB_W-1:0] cnt;
  logic [CPB_W-1:0] cpb;
  logic [CPB_W-1:0] half_m1;
  logic [CPB_W-1:0] bit_m1;
  logic [2:0]       idx;
  logic [7:0]       shift;
  logic             push;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          do_pop;
  logic          do_push;

  // Synchroniser resets to the idle (high) line level so reset never looks like a start bit.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) sync_q <= '1;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], i_RX_Serial};
  end

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign half_m1 = (cpb >> 1) - CNT_ONE;
  assign bit_m1  = cpb - CNT_ONE;

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state       <= IDLE;
      cnt         <= '0;
      cpb         <= '0;
      idx         <= '0;
      shift       <= '0;
      push        <= 1'b0;
      o_Frame_Err <= 1'b0;
    end else begin
      push <= 1'b0;
      if (i_Clr_Err) o_Frame_Err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
            cpb   <= i_Clk_per_bit;
          end
        end
        START: begin
          if (cnt == half_m1) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt == bit_m1) begin
            cnt        <= '0;
            shift[idx] <= rx_s;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        STOP: begin
          if (cnt == bit_m1) begin
            cnt <= '0;
            if (rx_s) begin
              push  <= 1'b1;
              state <= IDLE;
            end else begin
              o_Frame_Err <= 1'b1;
              state       <= WAIT_HI;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        WAIT_HI: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = i_RD && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      o_Overrun <= 1'b0;
    end else begin
      if (i_Clr_Err) o_Overrun <= 1'b0;
      if (push && full && !do_pop) o_Overrun <= 1'b1;
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= shift;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  assign o_RX_Byte   = mem[rd_ptr[AW-1:0]];
  assign o_RX_DV     = !empty;
  assign o_Full      = full;
  assign o_RX_Active = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: table-driven frames, hand-written corner
// sequences, and randomized frame batches scored against a byte-queue model.
module tb_uart_rx_fifo;

  logic        i_Clock = 1'b0;
  logic        i_Rst_L;
  logic        i_RX_Serial;
  logic [11:0] i_Clk_per_bit;
  logic        i_RD;
  logic        i_Clr_Err;
  logic [7:0]  o_RX_Byte;
  logic        o_RX_DV;
  logic        o_Full;
  logic        o_Frame_Err;
  logic        o_Overrun;
  logic        o_RX_Active;

  int n_vec = 0;
  int n_mis = 0;

  uart_rx_fifo dut (
    .i_Clock       (i_Clock),
    .i_Rst_L       (i_Rst_L),
    .i_RX_Serial   (i_RX_Serial),
    .i_Clk_per_bit (i_Clk_per_bit),
    .i_RD          (i_RD),
    .i_Clr_Err     (i_Clr_Err),
    .o_RX_Byte     (o_RX_Byte),
    .o_RX_DV       (o_RX_DV),
    .o_Full        (o_Full),
    .o_Frame_Err   (o_Frame_Err),
    .o_Overrun     (o_Overrun),
    .o_RX_Active   (o_RX_Active)
  );

  always #5 i_Clock = ~i_Clock;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         cpb;
    logic       exp_dv;
    logic [7:0] exp_byte;
    logic       exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge i_Clock);
  endtask

  // Drives one 8N1 frame at the given period; optionally holds the line low afterwards.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int cpb, input int low_hold);
    i_RX_Serial = 1'b0;
    wait_cycles(cpb);
    for (int i = 0; i < 8; i++) begin
      i_RX_Serial = d[i];
      wait_cycles(cpb);
    end
    i_RX_Serial = stop;
    wait_cycles(cpb);
    if (low_hold > 0) begin
      i_RX_Serial = 1'b0;
      wait_cycles(low_hold);
    end
    i_RX_Serial = 1'b1;
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    checkOutput({name, " dv"}, o_RX_DV, 1'b1);
    checkOutput(name, o_RX_Byte, exp);
    i_RD = 1'b1;
    @(negedge i_Clock);
    i_RD = 1'b0;
  endtask

  task automatic clear_errors(input string name);
    i_Clr_Err = 1'b1;
    @(negedge i_Clock);
    i_Clr_Err = 1'b0;
    @(negedge i_Clock);
    checkOutput({name, " frame_err cleared"}, o_Frame_Err, 1'b0);
    checkOutput({name, " overrun cleared"}, o_Overrun, 1'b0);
  endtask

  task automatic wait_active(input logic level, input int limit, input string name);
    int n;
    n = 0;
    while (o_RX_Active !== level && n < limit) begin
      @(negedge i_Clock);
      n++;
    end
    if (o_RX_Active !== level) checkOutput({name, " timeout"}, o_RX_Active, level);
  endtask

  task automatic applyStimulus(input vec_t v);
    i_Clk_per_bit = 12'(v.cpb);
    send_frame(v.data, v.stop, v.cpb, 0);
    wait_cycles(6);
  endtask

  initial begin
    int lat;
    logic [7:0] q[$];
    logic m_ferr, m_ovr;

    vecs[0] = '{8'hAF, 1'b1, 16,  1'b1, 8'hAF, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 8,   1'b1, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 9,   1'b1, 8'hFF, 1'b0};
    vecs[3] = '{8'h55, 1'b0, 12,  1'b0, 8'h00, 1'b1};
    vecs[4] = '{8'h80, 1'b1, 31,  1'b1, 8'h80, 1'b0};
    vecs[5] = '{8'h01, 1'b1, 255, 1'b1, 8'h01, 1'b0};

    i_Rst_L = 1'b0;
    i_RX_Serial = 1'b1;
    i_Clk_per_bit = 12'd16;
    i_RD = 1'b0;
    i_Clr_Err = 1'b0;
    wait_cycles(4);
    checkOutput("reset dv", o_RX_DV, 1'b0);
    checkOutput("reset byte", o_RX_Byte, 8'h00);
    checkOutput("reset full", o_Full, 1'b0);
    checkOutput("reset frame_err", o_Frame_Err, 1'b0);
    checkOutput("reset overrun", o_Overrun, 1'b0);
    checkOutput("reset active", o_RX_Active, 1'b0);
    i_Rst_L = 1'b1;
    wait_cycles(4);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d dv", i), o_RX_DV, vecs[i].exp_dv);
      if (vecs[i].exp_dv) checkOutput($sformatf("vec%0d byte", i), o_RX_Byte, vecs[i].exp_byte);
      checkOutput($sformatf("vec%0d frame_err", i), o_Frame_Err, vecs[i].exp_err);
      checkOutput($sformatf("vec%0d overrun", i), o_Overrun, 1'b0);
      if (o_RX_DV) begin
        i_RD = 1'b1;
        @(negedge i_Clock);
        i_RD = 1'b0;
        checkOutput($sformatf("vec%0d dv after pop", i), o_RX_DV, 1'b0);
      end
      clear_errors($sformatf("vec%0d", i));
    end

    // 9600 baud at 32 MHz; the programmed period changes mid-frame and must be ignored.
    i_Clk_per_bit = 12'hD05;
    fork
      send_frame(8'hAF, 1'b1, 3333, 0);
    join_none
    lat = 0;
    while (!o_RX_DV && lat < 40000) begin
      @(negedge i_Clock);
      lat++;
      if (lat == 100) i_Clk_per_bit = 12'd8;
    end
    checkOutput("9600 latency in window", (lat >= 31600 && lat <= 31750), 1'b1);
    checkOutput("9600 byte", o_RX_Byte, 8'hAF);
    wait fork;
    wait_cycles(4);
    checkOutput("9600 frame_err", o_Frame_Err, 1'b0);
    checkOutput("9600 overrun", o_Overrun, 1'b0);
    pop_check("9600 pop", 8'hAF);
    checkOutput("9600 dv after pop", o_RX_DV, 1'b0);

    // Back-to-back frames, no reads in between.
    i_Clk_per_bit = 12'd16;
    send_frame(8'hAF, 1'b1, 16, 0);
    send_frame(8'hCD, 1'b1, 16, 0);
    wait_cycles(4);
    pop_check("b2b first", 8'hAF);
    pop_check("b2b second", 8'hCD);
    checkOutput("b2b dv empty", o_RX_DV, 1'b0);

    // Short low glitch is rejected at the half-bit start check.
    i_Clk_per_bit = 12'hD05;
    i_RX_Serial = 1'b0;
    wait_cycles(500);
    checkOutput("glitch active during", o_RX_Active, 1'b1);
    wait_cycles(500);
    i_RX_Serial = 1'b1;
    wait_cycles(3000);
    checkOutput("glitch active after", o_RX_Active, 1'b0);
    checkOutput("glitch dv", o_RX_DV, 1'b0);
    checkOutput("glitch frame_err", o_Frame_Err, 1'b0);

    // Framing error followed by a long break.
    i_Clk_per_bit = 12'd16;
    send_frame(8'h55, 1'b0, 16, 16 * 5);
    wait_cycles(6);
    checkOutput("break frame_err", o_Frame_Err, 1'b1);
    checkOutput("break dv", o_RX_DV, 1'b0);
    checkOutput("break active", o_RX_Active, 1'b0);
    clear_errors("break");

    // Overflow: fifth byte dropped.
    i_Clk_per_bit = 12'd10;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 10, 0);
    wait_cycles(4);
    checkOutput("ovf full", o_Full, 1'b1);
    checkOutput("ovf overrun", o_Overrun, 1'b1);
    for (int i = 1; i <= 4; i++) pop_check($sformatf("ovf read%0d", i), 8'(i));
    checkOutput("ovf empty", o_RX_DV, 1'b0);
    clear_errors("ovf");

    // Pop on the exact cycle the fifth byte is pushed: both succeed.
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 10, 0);
    wait_cycles(4);
    checkOutput("simul full before", o_Full, 1'b1);
    fork
      send_frame(8'h05, 1'b1, 10, 0);
    join_none
    wait_active(1'b1, 50, "simul start");
    wait_active(1'b0, 400, "simul end");
    checkOutput("simul head", o_RX_Byte, 8'h01);
    i_RD = 1'b1;
    @(negedge i_Clock);
    i_RD = 1'b0;
    wait fork;
    wait_cycles(4);
    checkOutput("simul overrun", o_Overrun, 1'b0);
    checkOutput("simul full after", o_Full, 1'b1);
    for (int i = 2; i <= 5; i++) pop_check($sformatf("simul read%0d", i), 8'(i));

    // Asynchronous reset during data bit 4 with a byte already queued.
    i_Clk_per_bit = 12'd16;
    send_frame(8'h3C, 1'b1, 16, 0);
    wait_cycles(4);
    checkOutput("rst preload dv", o_RX_DV, 1'b1);
    fork
      send_frame(8'hCD, 1'b1, 16, 0);
    join_none
    wait_cycles(16 + 4 * 16 + 8);
    #2 i_Rst_L = 1'b0;
    #1;
    checkOutput("midrst dv", o_RX_DV, 1'b0);
    checkOutput("midrst byte", o_RX_Byte, 8'h00);
    checkOutput("midrst full", o_Full, 1'b0);
    checkOutput("midrst active", o_RX_Active, 1'b0);
    checkOutput("midrst frame_err", o_Frame_Err, 1'b0);
    wait fork;
    @(negedge i_Clock);
    i_Rst_L = 1'b1;
    wait_cycles(4);
    send_frame(8'hCD, 1'b1, 16, 0);
    wait_cycles(4);
    pop_check("postrst read", 8'hCD);
    checkOutput("postrst empty", o_RX_DV, 1'b0);

    // Randomized batches against a bounded byte-queue model.
    for (int b = 0; b < 6; b++) begin
      int cpb, k;
      cpb = $urandom_range(8, 24);
      k = $urandom_range(1, 6);
      i_Clk_per_bit = 12'(cpb);
      q.delete();
      m_ferr = 1'b0;
      m_ovr = 1'b0;
      for (int f = 0; f < k; f++) begin
        logic [7:0] d;
        logic bad;
        d = 8'($urandom);
        bad = ($urandom_range(0, 4) == 0);
        if (bad) begin
          send_frame(d, 1'b0, cpb, 2 * cpb);
          wait_cycles(cpb);
          m_ferr = 1'b1;
        end else begin
          send_frame(d, 1'b1, cpb, 0);
          wait_cycles($urandom_range(0, cpb));
          if (q.size() < 4) q.push_back(d);
          else m_ovr = 1'b1;
        end
      end
      wait_cycles(cpb);
      checkOutput($sformatf("rnd%0d dv", b), o_RX_DV, (q.size() > 0));
      checkOutput($sformatf("rnd%0d full", b), o_Full, (q.size() == 4));
      checkOutput($sformatf("rnd%0d frame_err", b), o_Frame_Err, m_ferr);
      checkOutput($sformatf("rnd%0d overrun", b), o_Overrun, m_ovr);
      while (q.size() > 0) pop_check($sformatf("rnd%0d read", b), q.pop_front());
      checkOutput($sformatf("rnd%0d empty", b), o_RX_DV, 1'b0);
      clear_errors($sformatf("rnd%0d", b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
